adc_temp_bcd_conv: RTL and testbench
====================================

Name: adc_temp_bcd_conv

Overview:
Sequential, parametrised converter from raw ADC temperature codes to packed-BCD degrees for the display and regulator path of the temperature controller.
- Block-averages 2^AVG_LOG2 samples, subtracts the sensor offset, and range-checks and clamps the result.
- Converts the result to BCD with an iterative shift-add-3 (double-dabble) engine.
- Presents the BCD value with a one-cycle valid strobe.
- Replaces the fixed 8-bit, 0..99 lookup decoding with configurable width, offset, range, digit count and out-of-range policy.

Parameters:
ADC_W, 8, ADC code width in bits
OFFSET, 56, ADC code that corresponds to 0 degrees
TEMP_MAX, 99, highest reportable temperature; must satisfy TEMP_MAX < 10^DIGITS
DIGITS, 2, number of BCD digits on Y
AVG_LOG2, 0, log2 of the number of samples averaged per conversion (0..4)
OOR_MODE, 0, 0 = substitute DEFAULT_TEMP when out of range; 1 = saturate to 0 or TEMP_MAX
DEFAULT_TEMP, 23, reset and substitute value in degrees; must be <= TEMP_MAX

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST_N  in  1  synchronous, active-low reset
A  in  ADC_W  raw ADC code
A_VALID  in  1  A is sampled on an edge where A_VALID=1 and BUSY=0
Y  out  4*DIGITS  packed BCD temperature; most-significant digit in the top nibble
Y_VALID  out  1  one-cycle strobe marking an updated Y
BUSY  out  1  high while converting; samples offered during this time are dropped
OOR  out  1  out-of-range flag for the last conversion, updated together with Y

Behaviour:
- Reset (RST_N=0 at an edge): Y = BCD(DEFAULT_TEMP), which is 0x23 with defaults; Y_VALID=0, BUSY=0, OOR=0; accumulator, sample counter and shift engine cleared; state=ACC. A reset mid-conversion aborts it, discards partial sums, and Y does not change beyond the reset value.
- Local constants:
  - BIN_W = clog2(TEMP_MAX+1), which is 7 with defaults.
  - SUM_W = ADC_W + AVG_LOG2.
- States:
  - ACC (BUSY=0): each accepted sample adds to sum and increments cnt. On the 2^AVG_LOG2-th accept, go to CALC.
  - CALC (BUSY=1), one cycle:
    - avg = sum >> AVG_LOG2 (truncating).
    - t = avg - OFFSET, computed signed at SUM_W+1 bits.
    - If t < 0: OOR=1; value = 0 in mode 1, DEFAULT_TEMP in mode 0.
    - If t > TEMP_MAX: OOR=1; value = TEMP_MAX in mode 1, DEFAULT_TEMP in mode 0.
    - Otherwise: OOR=0, value = t.
    - Load value (BIN_W bits) into the shift engine; go to SHIFT.
  - SHIFT (BUSY=1), exactly BIN_W cycles: in each cycle, add 3 to every BCD nibble >= 5, then shift left by one, bringing the binary MSB into BCD bit 0. After the last shift, go to DONE.
  - DONE (BUSY=1), one cycle: Y <= bcd, OOR <= oor_pending, Y_VALID <= 1 for the next cycle only; clear sum and cnt; go to ACC.
- Latency:
  - Y_VALID is high in the cycle following edge k+BIN_W+2, where k is the edge accepting the final sample. With defaults, that is 9 edges.
  - Throughput: one conversion per 2^AVG_LOG2 accepts plus BIN_W+2 busy cycles.
  - BUSY is already 0 in the cycle in which Y_VALID=1, so a sample accepted in that cycle begins the next average.
- A_VALID while BUSY=1: the sample is ignored and not queued; no error flag.
- Y and OOR hold their values between strobes. Y_VALID is never high for two consecutive cycles.
- Boundaries:
  - A = OFFSET gives 0.
  - A = OFFSET+TEMP_MAX gives TEMP_MAX with OOR=0.
  - One code beyond either limit gives OOR=1.
  - A = all-ones and A = 0 must not wrap; the signed arithmetic handles both.
- The accumulator never overflows, because SUM_W accommodates 2^AVG_LOG2 full-scale samples.

Decomposition:
- Package adc_temp_pkg:
  - state enum {ACC, CALC, SHIFT, DONE};
  - constant functions clog2() and to_bcd(value, digits), used to compute the reset value of Y at elaboration.
- Sub-module bin2bcd_seq:
  - parameters BIN_W and DIGITS;
  - ports CLK, RST_N, START, BIN, BCD, DONE;
  - contains the double-dabble shift register and shift counter.
- The top level holds the accumulator, offset and clamp logic, the FSM and the output registers.

Test Plan:
1. Defaults, hold RST_N=0 for 2 edges then release -> Y=0x23, Y_VALID=0, BUSY=0, OOR=0.
2. Single A=0x4E with A_VALID -> BUSY=1 next cycle; 9 edges later Y=0x22 and Y_VALID high for exactly one cycle, OOR=0.
3. Boundaries: A=0x38 -> Y=0x00, OOR=0; A=0x9B -> Y=0x99, OOR=0; A=0x37 -> Y=0x23, OOR=1; A=0xFF -> Y=0x23, OOR=1.
4. OOR_MODE=1: A=0x37 -> Y=0x00, OOR=1; A=0x9C -> Y=0x99, OOR=1; A=0x00 -> Y=0x00, OOR=1.
5. AVG_LOG2=2: samples 0x40, 0x41, 0x42, 0x43 -> sum 262, avg 65 -> Y=0x09 after the 4th accept + 9 edges.
6. Drop and abort:
   - A_VALID held every cycle with A=0x50 -> conversions spaced 10 cycles apart, each Y=0x24, intervening samples dropped;
   - RST_N pulsed during SHIFT -> Y=0x23, no Y_VALID, next A=0x60 -> Y=0x40.

Source files
------------

// File: rtl/adc_temp_pkg.sv
// Shared types and elaboration-time helpers for the ADC temperature-to-BCD converter.
package adc_temp_pkg;

   typedef enum logic [1:0] {ACC, CALC, SHIFT, DONE} state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Packed BCD of a non-negative integer, least-significant digit in bits [3:0].
   function automatic logic [63:0] to_bcd(input int value, input int digits);
      logic [63:0] r;
      int          v;
      r = '0;
      v = value;
      for (int i = 0; i < 16; i++) begin
         if (i < digits) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double-dabble) binary to packed-BCD converter, one bit per cycle.
module bin2bcd_seq #(
   parameter int BIN_W  = 7,
   parameter int DIGITS = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  START,
   input  logic [BIN_W-1:0]      BIN,
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  DONE
);

   localparam int SR_W  = 4*DIGITS + BIN_W;
   localparam int CNT_W = adc_temp_pkg::clog2(BIN_W + 1);

   logic [SR_W-1:0]  sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q;

   // BCD digits sit above the binary operand; each step corrects digits then shifts the whole register.
   always_comb begin
      sr_d = sr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_d[BIN_W + 4*i +: 4] >= 4'd5)
            sr_d[BIN_W + 4*i +: 4] = sr_d[BIN_W + 4*i +: 4] + 4'd3;
      end
      sr_d = sr_d << 1;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (START) begin
         sr_q  <= SR_W'(BIN);
         cnt_q <= CNT_W'(BIN_W);
      end else if (cnt_q != '0) begin
         sr_q  <= sr_d;
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign BCD  = sr_q[SR_W-1 -: 4*DIGITS];
   assign DONE = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/adc_temp_bcd_conv.sv
// Averages raw ADC temperature codes, removes the sensor offset, clamps to range
// and presents the result as packed BCD with a one-cycle valid strobe.
module adc_temp_bcd_conv
   import adc_temp_pkg::*;
#(
   parameter int ADC_W        = 8,
   parameter int OFFSET       = 56,
   parameter int TEMP_MAX     = 99,
   parameter int DIGITS       = 2,
   parameter int AVG_LOG2     = 0,
   parameter int OOR_MODE     = 0,
   parameter int DEFAULT_TEMP = 23
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [ADC_W-1:0]      A,
   input  logic                  A_VALID,
   output logic [4*DIGITS-1:0]   Y,
   output logic                  Y_VALID,
   output logic                  BUSY,
   output logic                  OOR
);

   localparam int BIN_W = clog2(TEMP_MAX + 1);
   localparam int SUM_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int NSAMP = 1 << AVG_LOG2;

   localparam logic [63:0]          Y_RST_FULL = to_bcd(DEFAULT_TEMP, DIGITS);
   localparam logic [4*DIGITS-1:0]  Y_RST      = Y_RST_FULL[4*DIGITS-1:0];
   localparam logic signed [SUM_W:0] OFFSET_S  = (SUM_W+1)'(OFFSET);
   localparam logic signed [SUM_W:0] TMAX_S    = (SUM_W+1)'(TEMP_MAX);

   // Returns {oor, value}; out-of-range policy is fixed at elaboration.
   function automatic logic [BIN_W:0] clamp_temp(input logic signed [SUM_W:0] t);
      logic             oor;
      logic [BIN_W-1:0] v;
      if (t < 0) begin
         oor = 1'b1;
         v   = (OOR_MODE != 0) ? '0 : BIN_W'(DEFAULT_TEMP);
      end else if (t > TMAX_S) begin
         oor = 1'b1;
         v   = (OOR_MODE != 0) ? BIN_W'(TEMP_MAX) : BIN_W'(DEFAULT_TEMP);
      end else begin
         oor = 1'b0;
         v   = t[BIN_W-1:0];
      end
      return {oor, v};
   endfunction

   state_e                state_q;
   logic [SUM_W-1:0]      sum_q, sum_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [4*DIGITS-1:0]   y_q;
   logic                  yv_q, busy_q, oor_q, oor_pend_q;

   logic [SUM_W-1:0]      avg;
   logic signed [SUM_W:0] t_s;
   logic [BIN_W:0]        clamp_res;
   logic                  eng_start, eng_done;
   logic [4*DIGITS-1:0]   eng_bcd;

   always_comb begin
      sum_d     = sum_q + SUM_W'(A);
      avg       = sum_q >> AVG_LOG2;
      t_s       = $signed({1'b0, avg}) - OFFSET_S;
      clamp_res = clamp_temp(t_s);
      eng_start = (state_q == CALC);
   end

   bin2bcd_seq #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_bcd (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (eng_start),
      .BIN   (clamp_res[BIN_W-1:0]),
      .BCD   (eng_bcd),
      .DONE  (eng_done)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= ACC;
         sum_q      <= '0;
         cnt_q      <= '0;
         y_q        <= Y_RST;
         yv_q       <= 1'b0;
         busy_q     <= 1'b0;
         oor_q      <= 1'b0;
         oor_pend_q <= 1'b0;
      end else begin
         yv_q <= 1'b0;
         case (state_q)
            ACC: begin
               if (A_VALID) begin
                  sum_q <= sum_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(NSAMP - 1)) begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            CALC: begin
               oor_pend_q <= clamp_res[BIN_W];
               state_q    <= SHIFT;
            end
            SHIFT: begin
               if (eng_done) state_q <= DONE;
            end
            DONE: begin
               y_q     <= eng_bcd;
               oor_q   <= oor_pend_q;
               yv_q    <= 1'b1;
               sum_q   <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= ACC;
            end
            default: state_q <= ACC;
         endcase
      end
   end

   assign Y       = y_q;
   assign Y_VALID = yv_q;
   assign BUSY    = busy_q;
   assign OOR     = oor_q;

endmodule

// File: tb/tb_adc_temp_bcd_conv.sv
// Bench for adc_temp_bcd_conv: default, saturating and 4-sample-averaging instances,
// table-driven conversions plus averaging, drop and abort sequences, queue scoreboard.
module tb_adc_temp_bcd_conv;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] a    [3];
   logic       av   [3];
   logic       rstn [3];
   logic [7:0] y    [3];
   logic       yv   [3];
   logic       busy [3];
   logic       oor  [3];

   adc_temp_bcd_conv dut0 (
      .CLK(clk), .RST_N(rstn[0]), .A(a[0]), .A_VALID(av[0]),
      .Y(y[0]), .Y_VALID(yv[0]), .BUSY(busy[0]), .OOR(oor[0]));

   adc_temp_bcd_conv #(.OOR_MODE(1)) dut1 (
      .CLK(clk), .RST_N(rstn[1]), .A(a[1]), .A_VALID(av[1]),
      .Y(y[1]), .Y_VALID(yv[1]), .BUSY(busy[1]), .OOR(oor[1]));

   adc_temp_bcd_conv #(.AVG_LOG2(2)) dut2 (
      .CLK(clk), .RST_N(rstn[2]), .A(a[2]), .A_VALID(av[2]),
      .Y(y[2]), .Y_VALID(yv[2]), .BUSY(busy[2]), .OOR(oor[2]));

   typedef struct {
      int         d;
      logic [7:0] y;
      logic       oor;
   } exp_t;

   typedef struct {
      int         d;
      logic [7:0] a;
      logic [7:0] y;
      logic       oor;
   } vec_t;

   exp_t sbq[$];
   exp_t mon_e;
   vec_t vecs[14];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_vcyc [3];
   logic prev_yv [3];
   logic spacing_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitor: every strobe is matched against the head of the scoreboard.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (yv[d] === 1'b1) begin
            chk($sformatf("dut%0d_y_valid_not_double", d), 32'(prev_yv[d]), 32'd0);
            chk($sformatf("dut%0d_busy_low_at_valid", d), 32'(busy[d]), 32'd0);
            if (spacing_on && d == 0 && last_vcyc[0] >= 0)
               chk("dut0_conversion_spacing", 32'(cyc - last_vcyc[0]), 32'd10);
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dut%0d_unexpected_valid: got Y=0x%0h, expected no strobe", d, y[d]);
            end else begin
               mon_e = sbq.pop_front();
               chk($sformatf("dut%0d_strobe_source", d), 32'(d), 32'(mon_e.d));
               chk($sformatf("dut%0d_y", d), 32'(y[d]), 32'(mon_e.y));
               chk($sformatf("dut%0d_oor", d), 32'(oor[d]), 32'(mon_e.oor));
            end
            last_vcyc[d] = cyc;
         end
         prev_yv[d] = yv[d];
      end
   end

   task automatic wait_idle(input int d);
      for (int i = 0; i < 40 && busy[d] !== 1'b0; i++) @(negedge clk);
      if (busy[d] !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL dut%0d_idle_timeout: got BUSY=%b, expected 0", d, busy[d]);
      end
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && sbq.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending results, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic convert(input int d, input logic [7:0] code, input logic [7:0] ey, input logic eo);
      exp_t e;
      int   acc;
      wait_idle(d);
      last_vcyc[d] = -1;
      e.d = d; e.y = ey; e.oor = eo;
      sbq.push_back(e);
      a[d]  = code;
      av[d] = 1'b1;
      @(posedge clk);
      #1;
      acc   = cyc;
      av[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("dut%0d_busy_after_accept_%0h", d, code), 32'(busy[d]), 32'd1);
      drain(40);
      chk($sformatf("dut%0d_latency_%0h", d, code), 32'(last_vcyc[d] - acc), 32'd9);
   endtask

   task automatic avg4(input logic [7:0] s0, s1, s2, s3, input logic [7:0] ey, input logic eo);
      exp_t       e;
      int         acc;
      logic [7:0] s [4];
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      wait_idle(2);
      last_vcyc[2] = -1;
      e.d = 2; e.y = ey; e.oor = eo;
      sbq.push_back(e);
      for (int i = 0; i < 4; i++) begin
         a[2]  = s[i];
         av[2] = 1'b1;
         @(posedge clk);
         #1;
      end
      acc   = cyc;
      av[2] = 1'b0;
      drain(40);
      chk("dut2_avg_latency", 32'(last_vcyc[2] - acc), 32'd9);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         a[d] = 8'h00; av[d] = 1'b0; rstn[d] = 1'b0;
         last_vcyc[d] = -1; prev_yv[d] = 1'b0;
      end

      vecs[0]  = '{0, 8'h4E, 8'h22, 1'b0};
      vecs[1]  = '{0, 8'h38, 8'h00, 1'b0};
      vecs[2]  = '{0, 8'h9B, 8'h99, 1'b0};
      vecs[3]  = '{0, 8'h37, 8'h23, 1'b1};
      vecs[4]  = '{0, 8'hFF, 8'h23, 1'b1};
      vecs[5]  = '{0, 8'h00, 8'h23, 1'b1};
      vecs[6]  = '{0, 8'h9C, 8'h23, 1'b1};
      vecs[7]  = '{0, 8'h50, 8'h24, 1'b0};
      vecs[8]  = '{1, 8'h37, 8'h00, 1'b1};
      vecs[9]  = '{1, 8'h9C, 8'h99, 1'b1};
      vecs[10] = '{1, 8'h00, 8'h00, 1'b1};
      vecs[11] = '{1, 8'hFF, 8'h99, 1'b1};
      vecs[12] = '{1, 8'h9B, 8'h99, 1'b0};
      vecs[13] = '{1, 8'h47, 8'h15, 1'b0};

      // Reset held for two edges on every instance.
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("dut%0d_reset_y", d), 32'(y[d]), 32'h23);
         chk($sformatf("dut%0d_reset_y_valid", d), 32'(yv[d]), 32'd0);
         chk($sformatf("dut%0d_reset_busy", d), 32'(busy[d]), 32'd0);
         chk($sformatf("dut%0d_reset_oor", d), 32'(oor[d]), 32'd0);
      end

      for (int i = 0; i < 14; i++)
         convert(vecs[i].d, vecs[i].a, vecs[i].y, vecs[i].oor);

      // Averaging: 262/4 = 65 -> 9; then 4 x full-scale -> 199 out of range.
      avg4(8'h40, 8'h41, 8'h42, 8'h43, 8'h09, 1'b0);
      avg4(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h23, 1'b1);
      avg4(8'h38, 8'h39, 8'h38, 8'h39, 8'h00, 1'b0);

      // Continuous A_VALID: one accept per 10 cycles, everything in between dropped.
      wait_idle(0);
      for (int i = 0; i < 4; i++) sbq.push_back('{0, 8'h24, 1'b0});
      last_vcyc[0] = -1;
      spacing_on   = 1'b1;
      a[0]  = 8'h50;
      av[0] = 1'b1;
      repeat (31) @(posedge clk);
      #1;
      av[0] = 1'b0;
      drain(60);
      repeat (12) @(negedge clk);
      spacing_on = 1'b0;
      chk("dut0_y_held_after_stream", 32'(y[0]), 32'h24);

      // Reset during SHIFT aborts the conversion.
      wait_idle(0);
      a[0]  = 8'h4E;
      av[0] = 1'b1;
      @(posedge clk);
      #1;
      av[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("dut0_busy_mid_shift", 32'(busy[0]), 32'd1);
      rstn[0] = 1'b0;
      @(posedge clk);
      #1;
      rstn[0] = 1'b1;
      @(negedge clk);
      #1;
      chk("dut0_abort_y", 32'(y[0]), 32'h23);
      chk("dut0_abort_busy", 32'(busy[0]), 32'd0);
      chk("dut0_abort_oor", 32'(oor[0]), 32'd0);
      repeat (15) @(negedge clk);
      chk("dut0_abort_y_unchanged", 32'(y[0]), 32'h23);
      convert(0, 8'h60, 8'h40, 1'b0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $fatal(1, "global timeout");
   end

endmodule
